// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle MIPS R-type execute controller driving a 32x32 register-file port.
// Optional build macro RTYPE_SHIFT_EN adds sll/srl/sra (funct 0x00/0x02/0x03).
//
// state  | meaning
// IDLE   | ready for a new instruction; read addresses latched on handshake
// READ   | register file presents operands; captured at end of cycle
// EXEC   | ALU result, flags and write-port values registered
// WB     | write port / done / err visible for exactly one cycle
module rtype_exec_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_Regs,
    input  logic              rst_n,
    input  logic [31:0]       inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              done,
    output logic              err,
    output logic              ZF,
    output logic              OF
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t state, state_nx;

    logic [5:0]        op_q;
    logic [5:0]        funct_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] opa, opb;
    logic [DATA_W-1:0] result;
    logic              legal;
    logic              ovf;

`ifdef RTYPE_SHIFT_EN
    logic [4:0] shamt_q;
`else
    // shamt has no consumer without the shift extension
    logic unused_shamt;
    assign unused_shamt = ^inst[10:6];
`endif

    always_ff @(posedge clk_Regs) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (inst_valid && inst_ready) state_nx = S_READ;
            S_READ: state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        legal  = 1'b0;
        ovf    = 1'b0;
        if (op_q == 6'h00) begin
            case (funct_q)
                6'h20: begin
                    result = opa + opb;
                    legal  = 1'b1;
                    ovf    = (opa[DATA_W-1] == opb[DATA_W-1]) && (result[DATA_W-1] != opa[DATA_W-1]);
                end
                6'h21: begin result = opa + opb; legal = 1'b1; end
                6'h22: begin
                    result = opa - opb;
                    legal  = 1'b1;
                    ovf    = (opa[DATA_W-1] != opb[DATA_W-1]) && (result[DATA_W-1] != opa[DATA_W-1]);
                end
                6'h23: begin result = opa - opb;    legal = 1'b1; end
                6'h24: begin result = opa & opb;    legal = 1'b1; end
                6'h25: begin result = opa | opb;    legal = 1'b1; end
                6'h26: begin result = opa ^ opb;    legal = 1'b1; end
                6'h27: begin result = ~(opa | opb); legal = 1'b1; end
                6'h2A: begin
                    result = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
                    legal  = 1'b1;
                end
                6'h2B: begin
                    result = {{(DATA_W-1){1'b0}}, (opa < opb)};
                    legal  = 1'b1;
                end
`ifdef RTYPE_SHIFT_EN
                6'h00: begin result = opb << shamt_q; legal = 1'b1; end
                6'h02: begin result = opb >> shamt_q; legal = 1'b1; end
                6'h03: begin result = DATA_W'($signed(opb) >>> shamt_q); legal = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_Regs) begin
        if (!rst_n) begin
            inst_ready <= 1'b1;
            R_Addr_A   <= '0;
            R_Addr_B   <= '0;
            Reg_Write  <= 1'b0;
            W_Addr     <= '0;
            W_Data     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            ZF         <= 1'b0;
            OF         <= 1'b0;
            op_q       <= '0;
            funct_q    <= '0;
            rd_q       <= '0;
            opa        <= '0;
            opb        <= '0;
`ifdef RTYPE_SHIFT_EN
            shamt_q    <= '0;
`endif
        end else begin
            inst_ready <= (state_nx == S_IDLE);
            Reg_Write  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inst_valid && inst_ready) begin
                        op_q     <= inst[31:26];
                        funct_q  <= inst[5:0];
                        rd_q     <= inst[15:11];
                        R_Addr_A <= inst[25:21];
                        R_Addr_B <= inst[20:16];
`ifdef RTYPE_SHIFT_EN
                        shamt_q  <= inst[10:6];
`endif
                    end
                end
                S_READ: begin
                    opa <= R_Data_A;
                    opb <= R_Data_B;
                end
                S_EXEC: begin
                    W_Addr    <= rd_q;
                    W_Data    <= result;
                    done      <= 1'b1;
                    err       <= !legal || ovf;
                    Reg_Write <= legal && !ovf && (rd_q != '0);
                    // illegal instructions must not disturb the flags
                    if (legal) begin
                        ZF <= (result == '0);
                        OF <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
